// File: rtl/keccak_block_padder.sv
// Keccak block padder: packs W-bit message words into RATE_WORDS-word
// blocks and applies multi-rate padding (PAD_BYTE ... 0x80).
// Ports: clk, reset_n (async, active-low); in/in_valid/is_last/byte_num
// word input, in_ready; out/out_valid/out_last block output, out_ack.
// Optional (KECCAK_PADDER_BLOCK_CNT_EN): block_cnt[31:0], msg_done.
module keccak_block_padder #(
    parameter int         W          = 64,
    parameter int         RATE_WORDS = 17,
    parameter logic [7:0] PAD_BYTE   = 8'h01
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [W-1:0]              in,
    input  logic                      in_valid,
    input  logic                      is_last,
    input  logic [$clog2(W/8)-1:0]    byte_num,
    output logic                      in_ready,
    output logic [W*RATE_WORDS-1:0]   out,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ack
`ifdef KECCAK_PADDER_BLOCK_CNT_EN
    ,
    output logic [31:0]               block_cnt,
    output logic                      msg_done
`endif
);

    localparam int NB = W / 8;
    localparam int CW = $clog2(RATE_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(RATE_WORDS - 1);

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        FULL   = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [W*RATE_WORDS-1:0] blk, blk_n;
    logic                    last_r, last_n;
    logic [W-1:0]            pad_word;
    logic [W-1:0]            word;
    logic                    shift;

    // Last word: keep bytes below byte_num, PAD_BYTE at byte_num, zero above.
    // Byte 0 is the most significant byte.
    always_comb begin
        pad_word = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < int'(byte_num))
                pad_word[W-1-8*i -: 8] = in[W-1-8*i -: 8];
            else if (i == int'(byte_num))
                pad_word[W-1-8*i -: 8] = PAD_BYTE;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        blk_n   = blk;
        last_n  = last_r;
        word    = '0;
        shift   = 1'b0;
        unique case (state)
            ACCEPT: begin
                if (in_valid) begin
                    shift  = 1'b1;
                    last_n = is_last;
                    word   = is_last ? pad_word : in;
                    if (cnt == LAST_IDX) begin
                        // Closing word of a padded block carries the 0x80.
                        if (is_last)
                            word[7:0] = word[7:0] | 8'h80;
                        state_n = FULL;
                    end else if (is_last) begin
                        state_n = PAD;
                    end
                end
            end
            PAD: begin
                shift = 1'b1;
                if (cnt == LAST_IDX) begin
                    word[7:0] = 8'h80;
                    state_n   = FULL;
                end
            end
            FULL: begin
                if (out_ack) begin
                    state_n = ACCEPT;
                    cnt_n   = '0;
                    last_n  = 1'b0;
                end
            end
            default: state_n = ACCEPT;
        endcase
        if (shift) begin
            blk_n        = blk << W;
            blk_n[W-1:0] = word;
            cnt_n        = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ACCEPT;
            cnt    <= '0;
            blk    <= '0;
            last_r <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            blk    <= blk_n;
            last_r <= last_n;
        end
    end

    assign in_ready  = (state == ACCEPT);
    assign out_valid = (state == FULL);
    assign out_last  = last_r;
    assign out       = blk;

`ifdef KECCAK_PADDER_BLOCK_CNT_EN
    logic done_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block_cnt <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= out_valid && out_ack && last_r;
            if (out_valid && out_ack)
                block_cnt <= block_cnt + 32'd1;
        end
    end

    assign msg_done = done_r;
`endif

endmodule

// File: tb/tb_keccak_block_padder.sv
// Directed bench for keccak_block_padder: a RATE_WORDS=2 instance and a
// default-rate instance, checked against hand-computed blocks.
module tb_keccak_block_padder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // RATE_WORDS=2 instance
    logic [63:0]   a_in;
    logic          a_valid, a_last, a_ready, a_ov, a_ol, a_oack;
    logic [2:0]    a_bn;
    logic [127:0]  a_out;

    // default-rate instance
    logic [63:0]   b_in;
    logic          b_valid, b_last, b_ready, b_ov, b_ol, b_oack;
    logic [2:0]    b_bn;
    logic [1087:0] b_out;

`ifdef KECCAK_PADDER_BLOCK_CNT_EN
    logic [31:0] a_bcnt, b_bcnt;
    logic        a_done, b_done;
`endif

    keccak_block_padder #(.W(64), .RATE_WORDS(2)) u_a (
        .clk(clk), .reset_n(reset_n),
        .in(a_in), .in_valid(a_valid), .is_last(a_last), .byte_num(a_bn),
        .in_ready(a_ready), .out(a_out), .out_valid(a_ov),
        .out_last(a_ol), .out_ack(a_oack)
`ifdef KECCAK_PADDER_BLOCK_CNT_EN
        , .block_cnt(a_bcnt), .msg_done(a_done)
`endif
    );

    keccak_block_padder u_b (
        .clk(clk), .reset_n(reset_n),
        .in(b_in), .in_valid(b_valid), .is_last(b_last), .byte_num(b_bn),
        .in_ready(b_ready), .out(b_out), .out_valid(b_ov),
        .out_last(b_ol), .out_ack(b_oack)
`ifdef KECCAK_PADDER_BLOCK_CNT_EN
        , .block_cnt(b_bcnt), .msg_done(b_done)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic a_word(input logic [63:0] w, input logic l,
                          input logic [2:0] bn);
        a_in = w; a_valid = 1'b1; a_last = l; a_bn = bn;
        @(negedge clk);
        a_valid = 1'b0; a_last = 1'b0;
    endtask

    task automatic b_word(input logic [63:0] w, input logic l,
                          input logic [2:0] bn);
        b_in = w; b_valid = 1'b1; b_last = l; b_bn = bn;
        @(negedge clk);
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic a_ackpulse();
        a_oack = 1'b1;
        @(negedge clk);
        a_oack = 1'b0;
    endtask

    initial begin
        logic [127:0]  held;
        logic [1087:0] expb;
        logic [63:0]   w;
        int            n;

        a_in = '0; a_valid = 0; a_last = 0; a_bn = '0; a_oack = 0;
        b_in = '0; b_valid = 0; b_last = 0; b_bn = '0; b_oack = 0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ov",   128'(a_ov),    128'(0));
        check("rst_ol",   128'(a_ol),    128'(0));
        check("rst_rdy",  128'(a_ready), 128'(1));
        check("rst_out",  a_out,         128'(0));
        check("rst_b_out", 128'(|b_out), 128'(0));
        reset_n = 1'b1;
        @(negedge clk);

        // two-word block, last word byte_num=3
        a_word(64'h1234567890ABCDEF, 1'b0, 3'd0);
        check("t1_rdy_mid", 128'(a_ready), 128'(1));
        check("t1_ov_mid",  128'(a_ov),    128'(0));
        a_word(64'hAABBCC0000000000, 1'b1, 3'd3);
        check("t1_ov",  128'(a_ov), 128'(1));
        check("t1_ol",  128'(a_ol), 128'(1));
        check("t1_out", a_out, 128'h1234567890ABCDEF_AABBCC0100000080);

        // stall in FULL with in_valid held high
        held = a_out;
        a_in = 64'hFFFFFFFFFFFFFFFF; a_valid = 1'b1; a_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_ov%0d", i),  128'(a_ov),    128'(1));
            check($sformatf("hold_rdy%0d", i), 128'(a_ready), 128'(0));
            check($sformatf("hold_out%0d", i), a_out,         held);
        end
        a_oack = 1'b1;
        @(negedge clk);
        a_oack = 1'b0; a_valid = 1'b0;
        check("ack_ov",  128'(a_ov),    128'(0));
        check("ack_rdy", 128'(a_ready), 128'(1));
        check("ack_out", a_out, 128'h1234567890ABCDEF_AABBCC0100000080);

        // single last word, byte_num=0: one PAD cycle
        a_word(64'hDEADBEEFDEADBEEF, 1'b1, 3'd0);
        check("t2_pad_rdy", 128'(a_ready), 128'(0));
        check("t2_pad_ov",  128'(a_ov),    128'(0));
        @(negedge clk);
        check("t2_ov",  128'(a_ov), 128'(1));
        check("t2_ol",  128'(a_ol), 128'(1));
        check("t2_out", a_out, 128'h0100000000000000_0000000000000080);
        a_ackpulse();

        // PAD_BYTE and 0x80 share the final byte
        a_word(64'h0F0E0D0C0B0A0908, 1'b0, 3'd0);
        a_word(64'h1122334455667700, 1'b1, 3'd7);
        check("t3_ov",  128'(a_ov), 128'(1));
        check("t3_ol",  128'(a_ol), 128'(1));
        check("t3_out", a_out, 128'h0F0E0D0C0B0A0908_1122334455667781);
        a_ackpulse();

        // default rate: full data block then a padding-only block
        expb = '0;
        for (int i = 0; i < 17; i++) begin
            w = 64'h0101010101010101 * 64'(i + 1);
            expb = (expb << 64) | 1088'(w);
            b_word(w, 1'b0, 3'd0);
            if (i == 15)
                check("b1_ov_early", 128'(b_ov), 128'(0));
        end
        check("b1_ov", 128'(b_ov), 128'(1));
        check("b1_ol", 128'(b_ol), 128'(0));
        for (int i = 0; i < 17; i++)
            check($sformatf("b1_w%0d", i), 128'(b_out[1087-64*i -: 64]),
                  128'(expb[1087-64*i -: 64]));
        b_oack = 1'b1;
        @(negedge clk);
        b_oack = 1'b0;
        check("b_ack_rdy", 128'(b_ready), 128'(1));
        b_word(64'h7777777777777777, 1'b1, 3'd0);
        n = 0;
        while (!b_ov && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2_latency", 128'(n), 128'(16));
        check("b2_ol", 128'(b_ol), 128'(1));
        expb = '0;
        expb[1087 -: 64] = 64'h0100000000000000;
        expb[63:0]       = 64'h0000000000000080;
        for (int i = 0; i < 17; i++)
            check($sformatf("b2_w%0d", i), 128'(b_out[1087-64*i -: 64]),
                  128'(expb[1087-64*i -: 64]));
        b_oack = 1'b1;
        @(negedge clk);
        b_oack = 1'b0;

`ifdef KECCAK_PADDER_BLOCK_CNT_EN
        check("a_bcnt", 128'(a_bcnt), 128'(3));
`endif
        // reset while in PAD
        a_word(64'h0123456789ABCDEF, 1'b1, 3'd2);
        check("r_in_pad", 128'(a_ready), 128'(0));
        reset_n = 1'b0;
        #1;
        check("r_ov",  128'(a_ov),    128'(0));
        check("r_ol",  128'(a_ol),    128'(0));
        check("r_rdy", 128'(a_ready), 128'(1));
        check("r_out", a_out,         128'(0));
`ifdef KECCAK_PADDER_BLOCK_CNT_EN
        check("r_bcnt", 128'(a_bcnt), 128'(0));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_block_padder.md
Name: keccak_block_padder

Overview:
- Sequential, parametrised successor to the combinational one-word padder.
- Accepts a message stream of W-bit words and assembles rate-sized blocks of RATE_WORDS words.
- Applies Keccak multi-rate padding across word and block boundaries: PAD_BYTE after the last data byte, 0x80 OR-ed into the final byte of the block.
- Sits between the input FIFO and the f_permutation core, which consumes one block per out_valid/out_ack handshake.

Parameters:
- W, 64: input word width in bits; multiple of 8, at least 16.
- RATE_WORDS, 17: words per block (17 x 64 = 1088-bit rate).
- PAD_BYTE, 8'h01: first padding byte; 8'h06 selects the SHA-3 domain.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in, input, W: message word; the first byte is in the MSBs.
- in_valid, input, 1: in is valid this cycle.
- is_last, input, 1: this word is the last word of the message.
- byte_num, input, log2(W/8): number of valid bytes in the last word, 0..W/8-1; ignored when is_last=0.
- in_ready, output, 1: the padder accepts a word this cycle.
- out, output, W*RATE_WORDS: assembled block; the first word is in the MSBs.
- out_valid, output, 1: out holds a complete block.
- out_last, output, 1: the valid block is the final block of the message.
- out_ack, input, 1: consumer takes the block; sampled only while out_valid=1.

Behaviour:
- Reset (async assert, sync deassert): state=ACCEPT, word count cnt=0, out=0, out_valid=0, out_last=0, in_ready=1.
- Handshake: a word is accepted when in_valid && in_ready.
  - in_ready = (state==ACCEPT).
  - Each accepted word shifts out left by W; the new word enters the LSBs; cnt increments.
- Non-last word: shifted in unmodified.
- Last word (is_last=1):
  - Bytes 0..byte_num-1 are kept.
  - Byte byte_num = PAD_BYTE.
  - Higher-index bytes = 0.
  - A full-length message ends with a separate is_last word with byte_num=0, which carries only padding.
- After the last word:
  - If cnt < RATE_WORDS-1, go to PAD and shift in one all-zero word per cycle until the block holds RATE_WORDS words.
  - No input is accepted in PAD.
- Final word of a padded block: byte W/8-1 (LSB byte) is OR-ed with 0x80 in the same cycle the word is written.
  - If PAD_BYTE lands in that same byte, the result is PAD_BYTE|0x80 (0x81 for the default PAD_BYTE).
- Block complete (cnt reaches RATE_WORDS):
  - Next cycle state=FULL, out_valid=1, in_ready=0.
  - out_last=1 if the block contains the padding.
  - Latency: the last data word of an unpadded block to out_valid is 1 cycle; a padded block adds RATE_WORDS-1-k PAD cycles, where k is the index of the last word.
- FULL + out_ack:
  - out_valid=0 on the next edge; cnt=0; out is held (not cleared); state=ACCEPT.
  - out_ack while out_valid=0 is ignored.
  - No word is accepted in the ack cycle (in_ready=0 throughout FULL).
- Non-last block ack: return to ACCEPT and continue the same message.
- out_last block ack: return to ACCEPT ready for a new message.
- in_valid while in_ready=0: ignored; the word is not consumed.
- reset_n low mid-block, in PAD or in FULL: all state is discarded immediately; outputs take their reset values.

Optional Feature:
- Macro: KECCAK_PADDER_BLOCK_CNT_EN.
- When defined:
  - Adds output block_cnt [31:0].
  - Increments on every out_valid && out_ack and wraps at 2^32.
  - Cleared by reset_n.
  - Adds output msg_done, a 1-cycle pulse on acknowledgement of an out_last block.
- When undefined: neither port exists, and behaviour is otherwise identical.

Test Plan:
- W=64, RATE_WORDS=2.
  - Stimulus: in=64'h1234567890ABCDEF (is_last=0), then is_last=1, byte_num=3, in=64'hAABBCC0000000000.
  - Required: out=128'h1234567890ABCDEF_AABBCC0100000080, out_valid=1, out_last=1.
- RATE_WORDS=2, single last word with byte_num=0.
  - Required: one PAD cycle, then out=128'h0100000000000000_0000000000000080.
- RATE_WORDS=2, last word is the 2nd word with byte_num=7, in=64'h1122334455667700.
  - Required: second word = 64'h1122334455667781 (combined 0x81 byte).
- Default params, 17 full words with is_last=0, then is_last=1 with byte_num=0.
  - Required: block 1 is out_last=0 with data unchanged; after out_ack, block 2 is out_last=1 with word0=64'h0100000000000000, words 1..15=0, word16=64'h0000000000000080.
- Handshake: hold out_ack=0 for 10 cycles with in_valid=1.
  - Required: out_valid and out stable, in_ready=0, no word consumed.
  - Then pulse out_ack: next cycle out_valid=0, in_ready=1.
- Assert reset_n=0 during PAD.
  - Required: out_valid=0, in_ready=1, out=0 immediately.
  - With KECCAK_PADDER_BLOCK_CNT_EN defined, block_cnt=0.
